// File: rtl/ne_window_detector.sv
// Windowed mean of the NE sample stream plus a hysteresis alarm on that mean.
// Optional macro NE_ABS_EN: accumulate |din| (most-negative saturates) instead of raw din.
module ne_window_detector #(
    parameter int input_width = 32,
    parameter int win_log2    = 4,
    parameter int hold_cnt    = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic signed [input_width:0]   din,
    input  logic                          din_valid,
    input  logic signed [input_width:0]   threshold,
    output logic signed [input_width:0]   dout,
    output logic                          data_valid,
    output logic                          detect,
    output logic [1:0]                    o_dbg_state
);

    localparam int DW = input_width + 1;
    localparam int AW = DW + win_log2;
    localparam logic [3:0] HOLD = 4'(hold_cnt);

    typedef enum logic [1:0] {
        QUIET   = 2'd0,
        PENDING = 2'd1,
        ALARM   = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t                r_state;
    logic [3:0]            r_run;
    logic signed [AW-1:0]  r_acc;
    logic [win_log2-1:0]   r_cnt;
    logic signed [DW-1:0]  r_dout;
    logic                  r_dv;
    logic                  r_detect;

    logic signed [DW-1:0]  w_sample;
    logic signed [AW-1:0]  w_sum;
    logic signed [DW-1:0]  w_mean;
    logic                  w_accept;
    logic                  w_last;
    logic                  w_above;
    logic [3:0]            w_run_inc;

`ifdef NE_ABS_EN
    // Negating the most-negative value would wrap, so clamp it to the largest positive.
    always_comb begin
        w_sample = din;
        if (din == {1'b1, {(DW-1){1'b0}}})
            w_sample = {1'b0, {(DW-1){1'b1}}};
        else if (din[DW-1])
            w_sample = -din;
    end
`else
    assign w_sample = din;
`endif

    assign w_accept  = en && din_valid;
    assign w_last    = &r_cnt;
    assign w_sum     = r_acc + {{win_log2{w_sample[DW-1]}}, w_sample};
    // Dropping the low win_log2 bits of a signed sum is an arithmetic shift (floor).
    assign w_mean    = w_sum[AW-1:win_log2];
    assign w_above   = (w_mean > threshold);
    assign w_run_inc = r_run + 4'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= QUIET;
            r_run    <= 4'd0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_dout   <= '0;
            r_dv     <= 1'b0;
            r_detect <= 1'b0;
        end else begin
            r_dv <= 1'b0;
            if (w_accept) begin
                r_cnt <= r_cnt + 1'b1;
                if (!w_last) begin
                    r_acc <= w_sum;
                end else begin
                    r_acc  <= '0;
                    r_dout <= w_mean;
                    r_dv   <= 1'b1;
                    case (r_state)
                        QUIET: begin
                            if (w_above) begin
                                if (HOLD == 4'd1) begin
                                    r_state  <= ALARM;
                                    r_detect <= 1'b1;
                                    r_run    <= 4'd0;
                                end else begin
                                    r_state <= PENDING;
                                    r_run   <= 4'd1;
                                end
                            end
                        end
                        PENDING: begin
                            if (!w_above) begin
                                r_state <= QUIET;
                                r_run   <= 4'd0;
                            end else if (w_run_inc >= HOLD) begin
                                r_state  <= ALARM;
                                r_detect <= 1'b1;
                                r_run    <= 4'd0;
                            end else begin
                                r_run <= w_run_inc;
                            end
                        end
                        ALARM: begin
                            if (w_above) begin
                                r_run <= 4'd0;
                            end else if (HOLD == 4'd1) begin
                                r_state  <= QUIET;
                                r_detect <= 1'b0;
                                r_run    <= 4'd0;
                            end else begin
                                r_state <= RELEASE;
                                r_run   <= 4'd1;
                            end
                        end
                        RELEASE: begin
                            if (w_above) begin
                                r_state <= ALARM;
                                r_run   <= 4'd0;
                            end else if (w_run_inc >= HOLD) begin
                                r_state  <= QUIET;
                                r_detect <= 1'b0;
                                r_run    <= 4'd0;
                            end else begin
                                r_run <= w_run_inc;
                            end
                        end
                        default: begin
                            r_state <= QUIET;
                            r_run   <= 4'd0;
                        end
                    endcase
                end
            end
        end
    end

    assign dout        = r_dout;
    assign data_valid  = r_dv;
    assign detect      = r_detect;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_ne_window_detector.sv
// Directed bench for ne_window_detector with 4-sample windows, hold of 2, threshold 100.
module tb_ne_window_detector;

  localparam int IW = 32;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 en = 1'b0;
  logic signed [IW:0]   din = '0;
  logic                 din_valid = 1'b0;
  logic signed [IW:0]   threshold = 33'sd100;
  logic signed [IW:0]   dout;
  logic                 data_valid;
  logic                 detect;
  logic [1:0]           o_dbg_state;

  int n_chk  = 0;
  int n_pass = 0;

  ne_window_detector #(
    .input_width (IW),
    .win_log2    (2),
    .hold_cnt    (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .din         (din),
    .din_valid   (din_valid),
    .threshold   (threshold),
    .dout        (dout),
    .data_valid  (data_valid),
    .detect      (detect),
    .o_dbg_state (o_dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Presents one valid sample and returns #1 after the edge that accepts it.
  task automatic send(input logic signed [IW:0] v);
    en        = 1'b1;
    din       = v;
    din_valid = 1'b1;
    @(posedge clk);
    #1;
    din_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send4(input logic signed [IW:0] a, input logic signed [IW:0] b,
                       input logic signed [IW:0] c, input logic signed [IW:0] d);
    send(a);
    send(b);
    send(c);
    send(d);
  endtask

  initial begin
    // Reset state
    idle(3);
    check("rst_dout", $signed(dout), 0);
    check("rst_dv", data_valid, 0);
    check("rst_detect", detect, 0);
    check("rst_state", o_dbg_state, 0);
    rst = 1'b0;
    idle(1);

    // 1: reset mid-window discards the partial sums
    send(33'sd7);
    send(33'sd9);
    rst = 1'b1;
    #2;
    check("t1_rst_dout", $signed(dout), 0);
    check("t1_rst_dv", data_valid, 0);
    check("t1_rst_detect", detect, 0);
    rst = 1'b0;
    idle(1);
    send4(33'sd10, 33'sd20, 33'sd30, 33'sd40);
    check("t1_dout", $signed(dout), 25);
    check("t1_dv", data_valid, 1);

    // 2: plain window, one-cycle data_valid pulse
    idle(1);
    check("t2_dv_pre", data_valid, 0);
    send4(33'sd10, 33'sd20, 33'sd30, 33'sd40);
    check("t2_dout", $signed(dout), 25);
    check("t2_dv", data_valid, 1);
    check("t2_detect", detect, 0);
    idle(1);
    check("t2_dv_drop", data_valid, 0);

    // 4: en low while din_valid high ignores 999 and holds progress
    send(33'sd10);
    send(33'sd20);
    en        = 1'b0;
    din       = 33'sd999;
    din_valid = 1'b1;
    idle(3);
    check("t4_no_dv", data_valid, 0);
    din_valid = 1'b0;
    send(33'sd30);
    send(33'sd40);
    check("t4_dout", $signed(dout), 25);
    check("t4_dv", data_valid, 1);

    // Mean equal to threshold is not above: stays QUIET
    send4(33'sd100, 33'sd100, 33'sd100, 33'sd100);
    check("eq_dout", $signed(dout), 100);
    check("eq_state", o_dbg_state, 0);

    // 3: two back-to-back windows above threshold
    send4(33'sd200, 33'sd200, 33'sd200, 33'sd200);
    check("t3_w1_dout", $signed(dout), 200);
    check("t3_w1_detect", detect, 0);
    check("t3_w1_state", o_dbg_state, 1);
    send4(33'sd200, 33'sd200, 33'sd200, 33'sd200);
    check("t3_w2_dv", data_valid, 1);
    check("t3_w2_detect", detect, 1);
    check("t3_w2_state", o_dbg_state, 2);

    // en=0 does not disturb the alarm
    en = 1'b0;
    idle(4);
    check("hold_detect", detect, 1);
    check("hold_state", o_dbg_state, 2);

    // 5: release hysteresis
    send4(33'sd50, 33'sd50, 33'sd50, 33'sd50);
    check("t5_a_dout", $signed(dout), 50);
    check("t5_a_detect", detect, 1);
    check("t5_a_state", o_dbg_state, 3);
    send4(33'sd200, 33'sd200, 33'sd200, 33'sd200);
    check("t5_b_detect", detect, 1);
    check("t5_b_state", o_dbg_state, 2);
    send4(33'sd50, 33'sd50, 33'sd50, 33'sd50);
    check("t5_c_detect", detect, 1);
    send4(33'sd50, 33'sd50, 33'sd50, 33'sd50);
    check("t5_d_detect", detect, 0);
    check("t5_d_state", o_dbg_state, 0);

    // 6: floor on negative means, and the abs option
    send4(-33'sd5, 33'sd0, 33'sd0, 33'sd0);
`ifdef NE_ABS_EN
    check("t6_floor", $signed(dout), 1);
`else
    check("t6_floor", $signed(dout), -2);
`endif
    send4(-33'sd8, -33'sd8, -33'sd8, -33'sd8);
`ifdef NE_ABS_EN
    check("t6_neg8", $signed(dout), 8);
`else
    check("t6_neg8", $signed(dout), -8);
`endif
    check("t6_detect", detect, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ne_window_detector.md
Name: ne_window_detector

Overview:
- Consumes the NE sample stream from ne_comp_unit, i.e. the `dout`/`data_valid` pair.
- Accumulates 2^win_log2 valid NE samples per window and emits the window mean.
- Runs a hysteresis FSM that raises a level `detect` flag after `hold_cnt` consecutive windows above threshold.
- Clears `detect` after `hold_cnt` consecutive windows at or below threshold.

Parameters:
input_width, 32, NE source sample width; NE values are input_width+1 bits signed
win_log2, 4, log2 of window length (window = 16 samples)
hold_cnt, 3, consecutive windows needed to enter or leave alarm (1..15)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
en  input  1  block enable; low pauses accumulation
din  input  input_width+1  signed NE sample (ne_comp_unit dout)
din_valid  input  1  din qualifier (ne_comp_unit data_valid)
threshold  input  input_width+1  signed compare level, sampled at window close
dout  output  input_width+1  signed window mean, registered
data_valid  output  1  one-cycle pulse, dout updated
detect  output  1  alarm level

Behaviour:
Reset:
- Async rst clears dout=0, data_valid=0, detect=0, accumulator=0, sample count=0, run counter=0, FSM=QUIET.
- Reset mid-window discards the partial window.

Accumulation:
- A sample is accepted when en && din_valid at a rising edge.
- Accumulator is signed, input_width+1+win_log2 bits wide, so it never overflows.
- If en=0, din_valid is ignored and the accumulator and count hold (pause, no restart).

Window close:
- Occurs when the accepted sample is number 2^win_log2 (count wraps to 0).
- Next edge: dout = (acc + din) >>> win_log2, an arithmetic shift, floor toward -inf, truncated to input_width+1 bits.
- data_valid=1 for exactly that one cycle; the accumulator reloads to 0 on the same edge.
- Back-to-back windows are legal: sample 1 of the next window may arrive on the cycle that closes the previous one.
- Latency: 1 clk from the last window sample to data_valid.

Detection FSM:
- Evaluated on the window-close edge with mean m; above = (m > threshold), signed compare.
- detect updates on the same edge as dout/data_valid.
- QUIET: above -> PENDING, run=1 (if hold_cnt=1, go directly to ALARM); else stay.
- PENDING: above -> run+1; when run reaches hold_cnt -> ALARM, detect=1, run=0. !above -> QUIET, run=0.
- ALARM: !above -> RELEASE, run=1 (if hold_cnt=1, go directly to QUIET, detect=0); above -> stay, run=0.
- RELEASE: !above -> run+1; when run reaches hold_cnt -> QUIET, detect=0, run=0. above -> ALARM, run=0.
- FSM and run counter hold between window closes.
- en=0 does not alter FSM state or detect.

Optional Feature:
NE_ABS_EN:
- Defined: each accepted din is replaced by |din| before accumulation.
- The most-negative value saturates to the most-positive value.
- dout is therefore never negative.
- Undefined: signed accumulation of raw din.

Test Plan:
Overrides for all tests: win_log2=2, hold_cnt=2, threshold=100.
1. Assert rst mid-window after 2 samples, release -> dout=0, data_valid=0, detect=0; next 4 samples 10,20,30,40 -> dout=25 (stale samples discarded).
2. din 10,20,30,40 on consecutive valid cycles -> one cycle after the 4th: dout=25, data_valid high for exactly 1 cycle, detect=0.
3. Two back-to-back windows of 200,200,200,200 -> after window 1: dout=200, detect=0 (PENDING); after window 2: detect=1 on the same edge as data_valid.
4. In window 1, drop en for 3 cycles while din_valid=1 with din=999 between samples 2 and 3 -> 999 ignored, dout=25 after 10,20,30,40.
5. From ALARM: window mean 50, then window mean 200 -> detect stays 1. Then two windows of mean 50 -> detect=0 at the second close.
6. din -5,0,0,0 -> dout=-2 (floor). din -8 x4 -> dout=-8 without NE_ABS_EN, dout=8 with NE_ABS_EN.
